msa_expander: RTL and testbench

Message-schedule expander for the SHA-256 datapath. Accepts one 512-bit chunk as sixteen 32-bit words and iteratively expands it into the 64-word message schedule array W[0..63]. Presents the full array on a valid/ready handshake to the downstream compression stage, which latches all 64 words in one transfer. Sits directly upstream of the compressor's `w` input.

---
 rtl/msa_expander.sv | 108 ++++++++++
 tb/tb_msa_expander.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/msa_expander.sv
// SHA-256 message-schedule expander: loads a 16-word chunk and expands it to W[0..63].
// Define MSA_EXPANDER_BYTESWAP_EN to byte-reverse every chunk word on load.

module msa_expander #(
   parameter int WORDS_PER_CYCLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              chunk_vld,
   output logic              chunk_rdy,
   input  logic [15:0][31:0] chunk,
   input  logic              w_rdy,
   output logic              w_vld,
   output logic [63:0][31:0] w
);

   // state  | meaning
   // IDLE   | waiting for a chunk, chunk_rdy high
   // EXPAND | computing W[idx .. idx+WORDS_PER_CYCLE-1] each cycle
   // HOLD   | full schedule presented, w_vld high until w_rdy

   if (WORDS_PER_CYCLE != 1 && WORDS_PER_CYCLE != 2 && WORDS_PER_CYCLE != 4 &&
       WORDS_PER_CYCLE != 8 && WORDS_PER_CYCLE != 16) begin : g_bad_wpc
      $error("msa_expander: WORDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   localparam logic [6:0] STEP = 7'(WORDS_PER_CYCLE);

   typedef enum logic [1:0] {
      IDLE,
      EXPAND,
      HOLD
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [6:0]        idx;
   logic [63:0][31:0] w_q;
   logic [63:0][31:0] win;
   logic [5:0]        t;
   logic              accept;
   logic              last;

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   function automatic logic [31:0] load_word(input logic [31:0] x);
`ifdef MSA_EXPANDER_BYTESWAP_EN
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
      return x;
`endif
   endfunction

   assign accept = (state == IDLE) & chunk_vld & chunk_rdy;
   assign last   = ((idx + STEP) == 7'd64);
   assign w      = w_q;

   // Words are written into a working copy in order, so any operand produced
   // earlier in the same cycle (t-2, and t-7/t-15 at wide settings) chains through.
   always_comb begin
      win = w_q;
      t   = '0;
      for (int j = 0; j < WORDS_PER_CYCLE; j++) begin
         t      = idx[5:0] + 6'(j);
         win[t] = sig1(win[t - 6'd2]) + win[t - 6'd7] + sig0(win[t - 6'd15]) + win[t - 6'd16];
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = EXPAND;
         EXPAND:  if (last) state_nxt = HOLD;
         HOLD:    if (w_vld & w_rdy) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         chunk_rdy <= 1'b0;
         w_vld     <= 1'b0;
         idx       <= '0;
         w_q       <= '0;
      end else begin
         state     <= state_nxt;
         chunk_rdy <= (state_nxt == IDLE);
         w_vld     <= (state_nxt == HOLD);
         if (accept) begin
            for (int i = 0; i < 16; i++) begin
               w_q[i] <= load_word(chunk[i]);
            end
            idx <= 7'd16;
         end else if (state == EXPAND) begin
            w_q <= win;
            idx <= idx + STEP;
         end
      end
   end

endmodule

// File: tb/tb_msa_expander.sv
// Directed bench for msa_expander: default build plus a WORDS_PER_CYCLE=4 instance,
// checked against a software SHA-256 schedule model and hand-computed words.

module tb_msa_expander;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [15:0][31:0] chunk = '0;
   logic              chunk_vld = 1'b0;
   logic              w_rdy = 1'b0;
   logic              chunk_rdy;
   logic              w_vld;
   logic [63:0][31:0] w;
   logic              chunk_vld4 = 1'b0;
   logic              w_rdy4 = 1'b0;
   logic              chunk_rdy4;
   logic              w_vld4;
   logic [63:0][31:0] w4;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   msa_expander u1 (
      .clk(clk), .rst_n(rst_n), .chunk_vld(chunk_vld), .chunk_rdy(chunk_rdy),
      .chunk(chunk), .w_rdy(w_rdy), .w_vld(w_vld), .w(w)
   );

   msa_expander #(.WORDS_PER_CYCLE(4)) u4 (
      .clk(clk), .rst_n(rst_n), .chunk_vld(chunk_vld4), .chunk_rdy(chunk_rdy4),
      .chunk(chunk), .w_rdy(w_rdy4), .w_vld(w_vld4), .w(w4)
   );

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [63:0][31:0] model(input logic [15:0][31:0] c);
      logic [63:0][31:0] m;
      logic [31:0] s0, s1;
      m = '0;
      for (int i = 0; i < 16; i++) begin
`ifdef MSA_EXPANDER_BYTESWAP_EN
         m[i] = {c[i][7:0], c[i][15:8], c[i][23:16], c[i][31:24]};
`else
         m[i] = c[i];
`endif
      end
      for (int i = 16; i < 64; i++) begin
         s0   = rotr(m[i-15], 7) ^ rotr(m[i-15], 18) ^ (m[i-15] >> 3);
         s1   = rotr(m[i-2], 17) ^ rotr(m[i-2], 19) ^ (m[i-2] >> 10);
         m[i] = s1 + m[i-7] + s0 + m[i-16];
      end
      return m;
   endfunction

   function automatic logic [15:0][31:0] pat(input int seed);
      logic [15:0][31:0] c;
      for (int i = 0; i < 16; i++) begin
         c[i] = 32'(seed) * 32'h9E3779B9 + 32'(i) * 32'h7F4A7C15 + 32'h0BADF00D;
      end
      return c;
   endfunction

   function automatic logic [15:0][31:0] abc_chunk();
      logic [15:0][31:0] c;
      c = '0;
`ifdef MSA_EXPANDER_BYTESWAP_EN
      c[0]  = 32'h80636261;
      c[15] = 32'h18000000;
`else
      c[0]  = 32'h61626380;
      c[15] = 32'h00000018;
`endif
      return c;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic check_arr(input string tag, input logic [63:0][31:0] got,
                            input logic [63:0][31:0] exp);
      int k;
      k = 0;
      for (int i = 63; i >= 0; i--) begin
         if (got[i] !== exp[i]) k = i;
      end
      check($sformatf("%s[%0d]", tag, k), got[k], exp[k]);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_w(input bit four, output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         tick();
         if ((four ? w_vld4 : w_vld) === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic accept(input bit four, input bit keep_vld);
      if (four) chunk_vld4 = 1'b1; else chunk_vld = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if ((four ? chunk_rdy4 : chunk_rdy) === 1'b1) break;
         tick();
      end
      tick();
      if (!keep_vld) begin
         if (four) chunk_vld4 = 1'b0; else chunk_vld = 1'b0;
      end
      check("acc_rdy_low", 32'(four ? chunk_rdy4 : chunk_rdy), 32'd0);
   endtask

   initial begin
      int n;
      int c1;
      int c2;
      logic [63:0][31:0] exp_w;

      #12;
      check("rst_rdy", 32'(chunk_rdy), 32'd0);
      check("rst_vld", 32'(w_vld), 32'd0);
      check_arr("rst_w", w, '0);
      check_arr("rst_w4", w4, '0);
      rst_n = 1'b1;
      tick();
      check("rdy_after_rst", 32'(chunk_rdy), 32'd1);

      // padded "abc"
      chunk = abc_chunk();
      accept(1'b0, 1'b0);
      wait_w(1'b0, n);
      check("abc_lat", 32'(n), 32'd48);
      check("abc_w0", w[0], 32'h61626380);
      check("abc_w15", w[15], 32'h00000018);
      check("abc_w16", w[16], 32'h61626380);
      check("abc_w17", w[17], 32'h000F0000);
      check_arr("abc_sched", w, model(abc_chunk()));

      // backpressure with a new chunk waiting
      chunk = pat(3);
      chunk_vld = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_vld", 32'(w_vld), 32'd1);
         check("bp_rdy", 32'(chunk_rdy), 32'd0);
         check_arr("bp_w", w, model(abc_chunk()));
      end
      w_rdy = 1'b1;
      tick();
      check("hs_vld_low", 32'(w_vld), 32'd0);
      check("hs_rdy_high", 32'(chunk_rdy), 32'd1);
      tick();
      check("bp_accept", 32'(chunk_rdy), 32'd0);
      chunk_vld = 1'b0;
      wait_w(1'b0, n);
      check("bp_lat", 32'(n), 32'd48);
      check_arr("bp_sched", w, model(pat(3)));
      tick();

      // back-to-back: all-zero chunk then pattern, w_rdy tied high
      chunk = '0;
      chunk_vld = 1'b1;
      for (int i = 0; i < 200 && chunk_rdy !== 1'b1; i++) tick();
      tick();
      c1 = cyc;
      chunk = pat(7);
      wait_w(1'b0, n);
      check("zero_lat", 32'(n), 32'd48);
      check_arr("zero_sched", w, '0);
      for (int i = 0; i < 200 && chunk_rdy !== 1'b1; i++) tick();
      tick();
      c2 = cyc;
      chunk_vld = 1'b0;
      check("b2b_spacing", 32'(c2 - c1), 32'd50);
      wait_w(1'b0, n);
      check("b2b_lat", 32'(n), 32'd48);
      check_arr("b2b_sched", w, model(pat(7)));
      tick();

      // reset while idx = 30
      w_rdy = 1'b0;
      chunk = pat(11);
      accept(1'b0, 1'b0);
      repeat (14) tick();
      check("mid_vld", 32'(w_vld), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_vld", 32'(w_vld), 32'd0);
      check("arst_rdy", 32'(chunk_rdy), 32'd0);
      check_arr("arst_w", w, '0);
      #3 rst_n = 1'b1;
      tick();
      check("rearm_rdy", 32'(chunk_rdy), 32'd1);
      w_rdy = 1'b1;
      accept(1'b0, 1'b0);
      wait_w(1'b0, n);
      check("post_rst_lat", 32'(n), 32'd48);
      check_arr("post_rst_sched", w, model(pat(11)));
      tick();
      check("post_rst_hs", 32'(w_vld), 32'd0);

      // four words per cycle
      chunk = abc_chunk();
      accept(1'b1, 1'b0);
      wait_w(1'b1, n);
      check("w4_abc_lat", 32'(n), 32'd12);
      check("w4_abc_w17", w4[17], 32'h000F0000);
      check_arr("w4_abc_sched", w4, model(abc_chunk()));
      w_rdy4 = 1'b1;
      tick();
      check("w4_hs", 32'(w_vld4), 32'd0);
      chunk = pat(21);
      exp_w = model(pat(21));
      accept(1'b1, 1'b0);
      wait_w(1'b1, n);
      check("w4_pat_lat", 32'(n), 32'd12);
      check_arr("w4_pat_sched", w4, exp_w);
      tick();
      chunk = '0;
      accept(1'b1, 1'b0);
      wait_w(1'b1, n);
      check("w4_zero_lat", 32'(n), 32'd12);
      check_arr("w4_zero_sched", w4, '0);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
